// File: rtl/if_id_register_pkg.sv
// Shared IF/ID pipeline definitions: data width, bubble encoding,
// flush PC and the IF->ID bundle used by the hazard unit and ID stage.
package if_id_register_pkg;

   localparam int          PIPE_DATA_W    = 32;
   localparam logic [31:0] PIPE_NOP_INSTR = 32'h0000_0000;
   localparam logic [31:0] PIPE_RESET_PC  = 32'h0000_0000;

   typedef struct packed {
      logic [PIPE_DATA_W-1:0] instr;
      logic [PIPE_DATA_W-1:0] pc;
   } if_id_t;

endpackage

// File: rtl/if_id_register_pipe_reg_en.sv
// Generic pipeline flop: async reset, synchronous clear, load enable.
// Clear and reset both load RST_VAL; clear beats enable.
module pipe_reg_en #(
   parameter int         W       = 32,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // reset > clear > enable > hold
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         q <= RST_VAL;
      else if (clr)
         q <= RST_VAL;
      else if (en)
         q <= d;
   end

endmodule

// File: rtl/if_id_register.sv
// IF/ID pipeline register with stall hold and branch-flush bubble.
// Optional Valid_out output when IF_ID_VALID_EN is defined.
module if_id_register
   import if_id_register_pkg::*;
#(
   parameter int                DATA_W    = PIPE_DATA_W,
   parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(PIPE_NOP_INSTR),
   parameter logic [DATA_W-1:0] RESET_PC  = DATA_W'(PIPE_RESET_PC)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [DATA_W-1:0] Instruction_in,
   input  logic [DATA_W-1:0] PC_in,
   input  logic              Branch_Control,
   output logic [DATA_W-1:0] Instruction_out,
   output logic [DATA_W-1:0] PC_out
`ifdef IF_ID_VALID_EN
   ,
   output logic              Valid_out
`endif
);

   // instruction slot; flush drops a NOP bubble into ID
   pipe_reg_en #(
      .W       (DATA_W),
      .RST_VAL (NOP_INSTR)
   ) u_instr (
      .clk (clk),
      .rst (reset),
      .clr (Branch_Control),
      .en  (enable),
      .d   (Instruction_in),
      .q   (Instruction_out)
   );

   // PC slot shares every control with the instruction slot
   pipe_reg_en #(
      .W       (DATA_W),
      .RST_VAL (RESET_PC)
   ) u_pc (
      .clk (clk),
      .rst (reset),
      .clr (Branch_Control),
      .en  (enable),
      .d   (PC_in),
      .q   (PC_out)
   );

`ifdef IF_ID_VALID_EN
   // valid marks a real fetched instruction, not a bubble
   pipe_reg_en #(
      .W       (1),
      .RST_VAL (1'b0)
   ) u_valid (
      .clk (clk),
      .rst (reset),
      .clr (Branch_Control),
      .en  (enable),
      .d   (1'b1),
      .q   (Valid_out)
   );
`endif

endmodule

// File: tb/tb_if_id_register.sv
// Scoreboard bench for if_id_register: driver pushes expected state,
// monitor pops and compares on every clock edge and reset assertion.
module tb_if_id_register;

   localparam logic [31:0] NOP = 32'h0000_0000;
   localparam logic [31:0] RPC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        enable = 1'b0;
   logic        bc = 1'b0;
   logic [31:0] instr_in = '0;
   logic [31:0] pc_in = '0;
   logic [31:0] instr_out;
   logic [31:0] pc_out;
   logic        valid_out;

   always #10 clk = ~clk;

   if_id_register dut (
      .clk             (clk),
      .reset           (rst),
      .enable          (enable),
      .Instruction_in  (instr_in),
      .PC_in           (pc_in),
      .Branch_Control  (bc),
      .Instruction_out (instr_out),
      .PC_out          (pc_out)
`ifdef IF_ID_VALID_EN
      ,
      .Valid_out       (valid_out)
`endif
   );

`ifndef IF_ID_VALID_EN
   assign valid_out = 1'b0;
`endif

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        valid;
   } exp_t;

   exp_t q[$];

   // reference state: what ID should currently be holding
   logic [31:0] m_instr = NOP;
   logic [31:0] m_pc    = RPC;
   logic        m_valid = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic push_state();
      exp_t e;
      e.instr = m_instr;
      e.pc    = m_pc;
      e.valid = m_valid;
      q.push_back(e);
   endtask

   // apply inputs; record expectations for any reset event and next edge
   task automatic drive(input logic r, input logic e, input logic b,
                        input logic [31:0] i, input logic [31:0] p);
      logic was_rst;
      was_rst  = rst;
      rst      = r;
      enable   = e;
      bc       = b;
      instr_in = i;
      pc_in    = p;
      if (r && !was_rst) begin
         m_instr = NOP;
         m_pc    = RPC;
         m_valid = 1'b0;
         push_state();
      end
      if (r || b) begin
         m_instr = NOP;
         m_pc    = RPC;
         m_valid = 1'b0;
      end else if (e) begin
         m_instr = i;
         m_pc    = p;
         m_valid = 1'b1;
      end
      push_state();
   endtask

   // monitor: every output-changing event consumes one expectation
   initial begin
      exp_t e;
      logic bad;
      forever begin
         @(posedge clk or posedge rst);
         #1;
         n_checks++;
         if (q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event t=%0t instr=%h pc=%h",
                     $time, instr_out, pc_out);
         end else begin
            e = q.pop_front();
            bad = (instr_out !== e.instr) || (pc_out !== e.pc);
`ifdef IF_ID_VALID_EN
            bad = bad || (valid_out !== e.valid);
`endif
            if (bad) begin
               n_fail++;
               $display("FAIL regs t=%0t got %h/%h/%b want %h/%h/%b",
                        $time, instr_out, pc_out, valid_out,
                        e.instr, e.pc, e.valid);
            end
         end
      end
   end

   initial begin
      #2;
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h1);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 32'h1234_5678, 32'h5);
      @(negedge clk);
      drive(1'b1, 1'b0, 1'b1, 32'h1234_5678, 32'h5);
      @(negedge clk);
      drive(1'b1, 1'b1, 1'b0, 32'hAAAA_5555, 32'h7);
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h2);
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b0, 32'h8C22_0004, 32'h4);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h8);
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b0, 32'h0000_1111, 32'hC);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 32'h0000_2222, 32'h10);
      @(negedge clk);
      drive(1'b1, 1'b0, 1'b0, 32'h0000_3333, 32'h14);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 32'h0000_4444, 32'h18);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 32'h0000_5555, 32'h1C);
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         drive(($urandom_range(0, 19) == 0),
               ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 4) == 0),
               $urandom, $urandom);
      end
      @(negedge clk);
      rst    = 1'b0;
      enable = 1'b0;
      bc     = 1'b0;
      #5;
      n_checks++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain pending=%0d want 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/if_id_register.md
# if_id_register

Pipeline register between the instruction-fetch (IF) and instruction-decode (ID) stages of the 5-stage MIPS core. It captures the fetched instruction and its PC on each rising clock edge. It holds its contents when the hazard unit stalls the front end. It loads a NOP bubble when a taken branch or misprediction squashes the fetched instruction.

## Interface
Parameters:
- DATA_W, 32: width of instruction and PC paths.
- NOP_INSTR, 32'h0000_0000: encoding loaded on flush and reset (MIPS `sll $0,$0,0`).
- RESET_PC, 32'h0000_0000: PC_out value after reset or flush.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clears the register immediately and is also driven by the branch-mispredict logic.
- enable  input  1  load enable; 0 = stall (hold), driven low by the hazard-detection unit.
- Instruction_in  input  DATA_W  instruction from instruction memory.
- PC_in  input  DATA_W  PC (or PC+4) of the fetched instruction.
- Branch_Control  input  1  synchronous flush request from branch resolution.
- Instruction_out  output  DATA_W  registered instruction to ID.
- PC_out  output  DATA_W  registered PC to ID.

## Operation
- All outputs come directly from flops, with no combinational path from the inputs.
- Priority, highest first: reset > Branch_Control > enable > hold.
- reset=1: Instruction_out=NOP_INSTR and PC_out=RESET_PC, asynchronously, with no clock required. Both values are held while reset stays high.
- Branch_Control=1 at a rising edge: load NOP_INSTR and RESET_PC. The flush wins even when enable=0, so a squash always clears the bubble.
- enable=1 and Branch_Control=0 at a rising edge: Instruction_out<=Instruction_in and PC_out<=PC_in.
- enable=0 and Branch_Control=0: both outputs hold their previous values (stall).
- Instruction and PC always update together. Neither is ever updated alone.
- Unknown (X) control inputs before the first defined reset or load may leave the outputs X. There is no requirement for X-suppression.

## Timing
- Load latency is 1 cycle: inputs sampled at rising edge N appear at the outputs after edge N.
- Reset assertion takes effect immediately, asynchronous to clk.
- Reset release is synchronised to the clock in the usual way. The first load occurs at the first rising edge with reset=0 and enable=1.
- Flush takes effect at the rising edge where Branch_Control=1 and lasts one cycle. The following edge loads normally if Branch_Control=0 and enable=1.
- If enable and Branch_Control toggle in the same cycle, only their values at the rising edge matter.
- If reset asserts mid-stall, it clears the register. After reset releases, the stall behaviour resumes and the outputs hold the NOP.

## Configuration
- Macro `IF_ID_VALID_EN`.
- When defined:
  - Adds output `Valid_out` (1 bit).
  - Valid_out is 0 after reset or flush, 1 after a normal load, and holds during a stall.
  - Valid_out follows the same priority rules and timing as the data outputs.
- When undefined: no Valid_out port. Behaviour of all other ports is identical.

## Structure
- Shared pipeline package: the DATA_W default, NOP_INSTR, RESET_PC, and an `if_id_t` struct {instr, pc} reused by the hazard unit and the ID stage.
- One sub-module is natural: `pipe_reg_en`, a generic DATA_W-wide flop with async reset, synchronous clear and enable.
  - Instantiate it once for the instruction, once for the PC, and optionally once for the valid bit.

## Test plan
Bench clock period is 20 ns, with rising edges at 10, 30, 50, ... ns. Inputs change on falling edges.
- Normal load: reset=0, enable=1, Branch_Control=0, Instruction_in=32'hFFFFFFFF, PC_in=32'h1 -> after the next rising edge, Instruction_out=32'hFFFFFFFF, PC_out=32'h1.
- Stall: enable=0 with the same inputs held or changed -> outputs stay 32'hFFFFFFFF / 32'h1 across 2+ edges.
- Async flush via reset: reset=1 (with Branch_Control=1) mid-cycle -> outputs become 32'h0 / 32'h0 before the next edge, and remain so while reset=1.
- Recovery: reset=0, enable=1, Instruction_in=32'h0, PC_in=32'h2 -> after the next edge, outputs 32'h0 / 32'h2.
- Synchronous flush beats stall: outputs loaded with 32'h8C220004 / 32'h4, then enable=0 and Branch_Control=1 -> after the edge, outputs 32'h0 / 32'h0. With Branch_Control=0 and enable=1 at the next edge, the new inputs load.
- With IF_ID_VALID_EN: Valid_out=0 after reset, 1 after the load, held during the stall, 0 after the flush.
